// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall sequencer for the 5-stage RV32I pipeline.
// Drives pipeline-register enables/flushes, EX forwarding selects, and freezes
// the pipe while a variable-latency data memory is busy (with timeout detection).
// Optional feature macro: HAZARD_PERF_CNT_EN builds saturating stall/flush counters;
// when undefined, stall_cnt/flush_cnt are tied to zero and no counter flops exist.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wcnt;
    logic       r_mem_err;

    logic w_mwait;
    logic w_lu;
    logic w_lu_eff;
    logic w_error;

    // EX operand source: MEM result beats WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_rw,
        input logic [4:0] w_rd,
        input logic       w_rw
    );
        logic [1:0] sel;
        if (m_rw && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = 2'b10;
        end else if (w_rw && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign w_mwait  = mem_req & ~mem_ready;
    assign w_lu     = ex_memread & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));
    // A taken branch kills the ID instruction, so its load-use stall is moot.
    assign w_lu_eff = w_lu & ~ex_branch_taken;
    assign w_error  = (r_state == ST_ERROR);
    assign mem_err  = r_mem_err;

    // Forwarding selects for both EX operands, independent of any stall.
    always_comb begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

    // Enable/flush generation in priority order: error, memory wait, branch, load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (w_error || w_mwait) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // Memory-wait timer: counts consecutive wait cycles and latches the timeout error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_wcnt    <= 8'd0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mwait) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= 8'd1;
                    end else begin
                        r_wcnt  <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready || !mem_req) begin
                        r_state <= ST_RUN;
                        r_wcnt  <= 8'd0;
                    end else if (r_wcnt == 8'(MEM_TIMEOUT)) begin
                        r_state   <= ST_ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                ST_ERROR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_wcnt    <= 8'd0;
                    r_mem_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_ev;
    logic             w_flush_ev;

    assign w_stall_ev = w_lu_eff | w_mwait | w_error;
    assign w_flush_ev = ifid_flush | idex_flush;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    // Saturating performance counters for stall and flush cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_ev && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush_ev && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
